// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: RV32I PC and instruction-fetch sequencer; FE_MISALIGN_TRAP_EN traps misaligned redirects instead of aligning them
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] program_counter,
  output logic [31:0] pc_plus4,
  output logic        misalign_fault
);
  typedef enum logic [1:0] {IDLE_S, FETCH_S, HOLD_S, FAULT_S} state_t;
  state_t state, state_d;
  logic [31:0] pc_d, instr_d;
  assign pc_plus4 = program_counter + PC_STEP;
  assign imem_addr = program_counter;
  assign imem_req = state == FETCH_S;
  assign instr_valid = state == HOLD_S;
`ifdef FE_MISALIGN_TRAP_EN
  assign misalign_fault = state == FAULT_S;
`else
  assign misalign_fault = 1'b0;
`endif
  always_comb begin
    state_d = state;
    pc_d = program_counter;
    instr_d = instr;
    case (state)
      IDLE_S: state_d = FETCH_S;
      FETCH_S: begin
        state_d = imem_ack ? HOLD_S : FETCH_S;
        instr_d = imem_ack ? imem_rdata : instr;
      end
      HOLD_S: if (retire) begin
`ifdef FE_MISALIGN_TRAP_EN
        state_d = (redirect && |redirect_target[1:0]) ? FAULT_S : FETCH_S;
        pc_d = !redirect ? pc_plus4 : |redirect_target[1:0] ? program_counter : redirect_target;
`else
        state_d = FETCH_S;
        pc_d = redirect ? redirect_target & ~32'h3 : pc_plus4;
`endif
      end
      default: state_d = state;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE_S;
      program_counter <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_d;
      program_counter <= pc_d;
      instr <= instr_d;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plus random checks of pc_fetch_unit against a transaction-level model
module tb_pc_fetch_unit;
`ifdef FE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic imem_ack = 0, retire = 0, redirect = 0;
  logic [31:0] imem_rdata = 0, redirect_target = 0;
  logic imem_req, instr_valid, misalign_fault, imem_req2, instr_valid2, misalign_fault2;
  logic [31:0] imem_addr, instr, program_counter, pc_plus4;
  logic [31:0] imem_addr2, instr2, program_counter2, pc_plus42;
  int checks = 0, errors = 0;
  bit m_idle, m_req, m_valid, m_fault;
  logic [31:0] m_pc, m_pc2, m_instr;
  always #5 clk = ~clk;
  pc_fetch_unit dut (.clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .retire(retire), .redirect(redirect), .redirect_target(redirect_target),
    .program_counter(program_counter), .pc_plus4(pc_plus4), .misalign_fault(misalign_fault));
  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (.clk(clk), .rst(rst), .imem_req(imem_req2),
    .imem_addr(imem_addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr2),
    .instr_valid(instr_valid2), .retire(retire), .redirect(redirect),
    .redirect_target(redirect_target), .program_counter(program_counter2),
    .pc_plus4(pc_plus42), .misalign_fault(misalign_fault2));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_idle = 1; m_req = 0; m_valid = 0; m_fault = 0;
    m_pc = 32'h0040_0000; m_pc2 = 32'hFFFF_FFFC; m_instr = 0;
  endtask
  task automatic model_step();
    if (m_fault) return;
    if (m_idle) begin
      m_idle = 0; m_req = 1;
    end else if (m_req) begin
      if (imem_ack) begin m_instr = imem_rdata; m_valid = 1; m_req = 0; end
    end else if (m_valid && retire) begin
      m_valid = 0;
      if (!redirect) begin
        m_pc = m_pc + 4; m_pc2 = m_pc2 + 4; m_req = 1;
      end else if (TRAP && redirect_target % 4 != 0) begin
        m_fault = 1;
      end else begin
        m_pc = redirect_target - redirect_target % 4; m_pc2 = m_pc; m_req = 1;
      end
    end
  endtask
  task automatic compare_all();
    check("imem_req", 32'(imem_req), 32'(m_req));
    check("imem_addr", imem_addr, m_pc);
    check("program_counter", program_counter, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 4);
    check("instr", instr, m_instr);
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("misalign_fault", 32'(misalign_fault), 32'(m_fault));
    check("wrap_pc", program_counter2, m_pc2);
    check("wrap_req", 32'(imem_req2), 32'(m_req));
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask
  task automatic do_reset();
    rst = 1; imem_ack = 0; retire = 0; redirect = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    logic [31:0] t;
    int fault_cycles = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_pc", program_counter, 32'h0040_0000);
    check("reset_req", 32'(imem_req), 32'd0);
    rst = 0;
    cycle();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0040_0000);
    repeat (3) cycle();
    imem_ack = 1; imem_rdata = 32'h0050_0093;
    cycle();
    imem_ack = 0;
    check("instr_latched", instr, 32'h0050_0093);
    check("instr_valid_set", 32'(instr_valid), 32'd1);
    retire = 1;
    cycle();
    retire = 0;
    check("seq_addr", imem_addr, 32'h0040_0004);
    check("seq_plus4", pc_plus4, 32'h0040_0008);
    check("wrap_addr", imem_addr2, 32'h0000_0000);
    imem_ack = 1;
    cycle();
    imem_ack = 0; redirect = 1; redirect_target = 32'h0040_0100;
    repeat (2) cycle();
    retire = 1;
    cycle();
    retire = 0; redirect = 0;
    check("redirect_addr", imem_addr, 32'h0040_0100);
    imem_ack = 1;
    cycle();
    imem_ack = 0; retire = 1; redirect = 1; redirect_target = 32'h0040_0102;
    cycle();
    retire = 0; redirect = 0;
    if (TRAP) begin
      repeat (10) cycle();
      check("fault_set", 32'(misalign_fault), 32'd1);
      check("fault_req", 32'(imem_req), 32'd0);
      check("fault_pc", program_counter, 32'h0040_0100);
    end else
      check("aligned_addr", imem_addr, 32'h0040_0100);
    do_reset();
    cycle();
    repeat (2) cycle();
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    #2 rst = 1;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_valid", 32'(instr_valid), 32'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    imem_ack = 0; rst = 0;
    cycle();
    check("restart_addr", imem_addr, 32'h0040_0000);
    for (int i = 0; i < 3000; i++) begin
      imem_ack = m_req ? $urandom_range(0, 2) == 0 : $urandom_range(0, 9) == 0;
      imem_rdata = $urandom;
      retire = $urandom_range(0, 2) == 0;
      redirect = $urandom_range(0, 1) == 1;
      t = $urandom;
      redirect_target = $urandom_range(0, 15) == 0 ? t : t & ~32'h3;
      fault_cycles = m_fault ? fault_cycles + 1 : 0;
      if (fault_cycles > 10 || $urandom_range(0, 299) == 0) begin
        fault_cycles = 0;
        do_reset();
      end
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
